// File: rtl/simmem_resp_bank_reader.sv
// rtl/simmem_resp_bank_reader.sv - per-ID linked-list read-out engine of a simmem response bank
// Optional drained/stall counters: define SIMMEM_BANK_READER_STATS_EN.
module simmem_resp_bank_reader #(
  parameter int NumIds    = 4,
  parameter int IdWidth   = 2,
  parameter int NumSlots  = 16,
  parameter int SlotWidth = 4,
  parameter int DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 append_valid_i,
  input  logic [IdWidth-1:0]   append_id_i,
  input  logic [SlotWidth-1:0] append_slot_i,
  input  logic                 release_valid_i,
  input  logic [IdWidth-1:0]   release_id_i,
  output logic                 ram_req_o,
  output logic [SlotWidth-1:0] ram_addr_o,
  input  logic [DataWidth-1:0] struct_rdata_i,
  input  logic [SlotWidth-1:0] next_rdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdWidth-1:0]   resp_id_o,
  output logic [DataWidth-1:0] resp_data_o,
  output logic                 free_valid_o,
`ifdef SIMMEM_BANK_READER_STATS_EN
  output logic [31:0]          drained_cnt_o,
  output logic [31:0]          stall_cnt_o,
`endif
  output logic [SlotWidth-1:0] free_slot_o
);

  typedef enum logic [1:0] {IDLE, RD, OUT} state_e;

  localparam logic [SlotWidth:0] MaxCred = (SlotWidth+1)'(NumSlots);
  localparam logic [SlotWidth:0] CntOne  = (SlotWidth+1)'(1);

  state_e               state_q, state_d;
  logic [SlotWidth-1:0] head_q [NumIds];
  logic [SlotWidth-1:0] head_d [NumIds];
  logic [SlotWidth:0]   cnt_q  [NumIds];
  logic [SlotWidth:0]   cnt_d  [NumIds];
  logic [SlotWidth:0]   cred_q [NumIds];
  logic [SlotWidth:0]   cred_d [NumIds];

  logic [IdWidth-1:0]   cur_id_q, cur_id_d, last_id_q, last_id_d, resp_id_q, resp_id_d;
  logic [SlotWidth-1:0] cur_slot_q, cur_slot_d, nxt_q, nxt_d, free_slot_q, free_slot_d;
  logic                 link_q, link_d, resp_valid_q, resp_valid_d, free_valid_q, free_valid_d;
  logic [DataWidth-1:0] resp_data_q, resp_data_d;

  logic [NumIds-1:0]    elig;
  logic                 pick_vld;
  logic [IdWidth-1:0]   pick_id, cand;
  logic                 drain, app_cur;

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      elig[i] = (cnt_q[i] != '0) && (cred_q[i] != '0);
    end
  end

  // Round-robin search starts one past the most recently picked ID.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = 1; k <= NumIds; k++) begin
      cand = IdWidth'((int'(last_id_q) + k) % NumIds);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // Drain is applied before append so a same-cycle append to an emptied list becomes its head.
  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      head_d[i] = head_q[i];
      cnt_d[i]  = cnt_q[i];
      cred_d[i] = cred_q[i];
      if (drain && (cur_id_q == IdWidth'(i))) begin
        cnt_d[i]  = cnt_d[i] - CntOne;
        cred_d[i] = cred_d[i] - CntOne;
        if (cnt_d[i] != '0) head_d[i] = nxt_q;
      end
      if (append_valid_i && (append_id_i == IdWidth'(i))) begin
        if (cnt_d[i] == '0) head_d[i] = append_slot_i;
        cnt_d[i] = cnt_d[i] + CntOne;
      end
      if (release_valid_i && (release_id_i == IdWidth'(i)) && (cred_d[i] < MaxCred)) begin
        cred_d[i] = cred_d[i] + CntOne;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    cur_slot_d   = cur_slot_q;
    last_id_d    = last_id_q;
    nxt_d        = nxt_q;
    link_d       = link_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    free_valid_d = 1'b0;
    free_slot_d  = free_slot_q;
    ram_req_o    = 1'b0;
    ram_addr_o   = '0;
    drain        = 1'b0;
    // The slot in flight is its list's tail: a new append supersedes whatever link the RAM gave.
    app_cur      = append_valid_i && (append_id_i == cur_id_q) && (cnt_q[cur_id_q] == CntOne);
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          ram_req_o  = 1'b1;
          ram_addr_o = head_q[pick_id];
          cur_id_d   = pick_id;
          cur_slot_d = head_q[pick_id];
          last_id_d  = pick_id;
          link_d     = append_valid_i && (append_id_i == pick_id) && (cnt_q[pick_id] == CntOne);
          nxt_d      = append_slot_i;
          state_d    = RD;
        end
      end
      RD: begin
        resp_valid_d = 1'b1;
        resp_id_d    = cur_id_q;
        resp_data_d  = struct_rdata_i;
        if (!link_q) nxt_d = next_rdata_i;
        if (app_cur) begin
          nxt_d  = append_slot_i;
          link_d = 1'b1;
        end
        state_d = OUT;
      end
      OUT: begin
        if (resp_ready_i) begin
          drain        = 1'b1;
          resp_valid_d = 1'b0;
          free_valid_d = 1'b1;
          free_slot_d  = cur_slot_q;
          link_d       = 1'b0;
          state_d      = IDLE;
        end else if (app_cur) begin
          nxt_d = append_slot_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      cur_slot_q   <= '0;
      last_id_q    <= IdWidth'(NumIds - 1);
      nxt_q        <= '0;
      link_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      free_valid_q <= 1'b0;
      free_slot_q  <= '0;
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= '0;
        cnt_q[i]  <= '0;
        cred_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      cur_slot_q   <= cur_slot_d;
      last_id_q    <= last_id_d;
      nxt_q        <= nxt_d;
      link_q       <= link_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      free_valid_q <= free_valid_d;
      free_slot_q  <= free_slot_d;
      for (int i = 0; i < NumIds; i++) begin
        head_q[i] <= head_d[i];
        cnt_q[i]  <= cnt_d[i];
        cred_q[i] <= cred_d[i];
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign free_valid_o = free_valid_q;
  assign free_slot_o  = free_slot_q;

`ifdef SIMMEM_BANK_READER_STATS_EN
  logic [31:0] drained_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      drained_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (drain) drained_cnt_q <= drained_cnt_q + 32'd1;
      if (resp_valid_q && !resp_ready_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign drained_cnt_o = drained_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
`endif

  int total_cnt;

  always_comb begin
    total_cnt = 0;
    for (int i = 0; i < NumIds; i++) begin
      total_cnt = total_cnt + int'(cnt_q[i]);
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!$isunknown(append_valid_i) && !$isunknown(release_valid_i));
      assert (!append_valid_i || ((total_cnt - int'(drain)) < NumSlots));
    end
  end

endmodule
